// File: rtl/wb_dest_pipe.sv
// Writeback-destination pipeline: tracks register writers through STAGES
// registers and derives per-operand stall requests and forwarding selects.
module wb_dest_pipe #(
    parameter int ADDR_W = 5,
    parameter int STAGES = 3,
    parameter int TNEW_W = 2,
    parameter int NSRC   = 2,
    parameter int SEL_W  = $clog2(STAGES + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     d_we,
    input  logic                     d_nop,
    input  logic [ADDR_W-1:0]        d_dst,
    input  logic [TNEW_W-1:0]        d_tnew,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [NSRC*ADDR_W-1:0]   src_addr,
    input  logic [NSRC*TNEW_W-1:0]   src_tuse,
    output logic                     hz_stall,
    output logic [NSRC*SEL_W-1:0]    fwd_sel,
    output logic [STAGES-1:0]        stg_we,
    output logic [STAGES*ADDR_W-1:0] stg_dst
);

    // Index 0 holds stage 1 (E); index STAGES-1 is the oldest entry.
    logic              we_q   [STAGES];
    logic [ADDR_W-1:0] dst_q  [STAGES];
    logic [TNEW_W-1:0] tnew_q [STAGES];

    logic eff_we;

    assign eff_we = d_we & ~d_nop & (d_dst != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                we_q[k]   <= 1'b0;
                dst_q[k]  <= '0;
                tnew_q[k] <= '0;
            end
        end else begin
            if (stall | flush) begin
                we_q[0]   <= 1'b0;
                dst_q[0]  <= '0;
                tnew_q[0] <= '0;
            end else begin
                we_q[0]   <= eff_we;
                dst_q[0]  <= d_dst;
                tnew_q[0] <= d_tnew;
            end
            // Older stages shift unconditionally; countdown saturates at zero.
            for (int unsigned k = 1; k < STAGES; k++) begin
                we_q[k]   <= we_q[k-1];
                dst_q[k]  <= dst_q[k-1];
                tnew_q[k] <= (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - 1'b1;
            end
        end
    end

    always_comb begin
        stg_we  = '0;
        stg_dst = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            stg_we[k]                 = we_q[k];
            stg_dst[k*ADDR_W +: ADDR_W] = dst_q[k];
        end
    end

    logic              found;
    logic [ADDR_W-1:0] cur_src;
    logic [TNEW_W-1:0] cur_tuse;

    // Only the youngest matching writer counts, even when an older one is ready.
    always_comb begin
        hz_stall = 1'b0;
        fwd_sel  = '0;
        found    = 1'b0;
        cur_src  = '0;
        cur_tuse = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            found    = 1'b0;
            cur_src  = src_addr[i*ADDR_W +: ADDR_W];
            cur_tuse = src_tuse[i*TNEW_W +: TNEW_W];
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (!found && we_q[k] && (dst_q[k] == cur_src) && (cur_src != '0)) begin
                    found = 1'b1;
                    if (tnew_q[k] > cur_tuse)
                        hz_stall = 1'b1;
                    if (tnew_q[k] == '0)
                        fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_dest_pipe.sv
// Self-checking bench for wb_dest_pipe: directed vector table, hand sequences
// and randomized traffic against an age-based reference model.
module tb_wb_dest_pipe;

    localparam int AW = 5;
    localparam int ST = 3;
    localparam int TW = 2;
    localparam int NS = 2;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              d_we, d_nop;
    logic [AW-1:0]     d_dst;
    logic [TW-1:0]     d_tnew;
    logic              stall, flush;
    logic [NS*AW-1:0]  src_addr;
    logic [NS*TW-1:0]  src_tuse;
    logic              hz_stall;
    logic [NS*SW-1:0]  fwd_sel;
    logic [ST-1:0]     stg_we;
    logic [ST*AW-1:0]  stg_dst;

    wb_dest_pipe #(.ADDR_W(AW), .STAGES(ST), .TNEW_W(TW), .NSRC(NS), .SEL_W(SW)) dut (
        .clk(clk), .reset(reset), .d_we(d_we), .d_nop(d_nop), .d_dst(d_dst),
        .d_tnew(d_tnew), .stall(stall), .flush(flush), .src_addr(src_addr),
        .src_tuse(src_tuse), .hz_stall(hz_stall), .fwd_sel(fwd_sel),
        .stg_we(stg_we), .stg_dst(stg_dst)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic nop, input int dst, input int tnew,
                         input logic st, input logic fl);
        d_we = we; d_nop = nop; d_dst = AW'(dst); d_tnew = TW'(tnew);
        stall = st; flush = fl;
    endtask

    task automatic set_src(input int s0, input int s1, input int u0, input int u1);
        src_addr = {AW'(s1), AW'(s0)};
        src_tuse = {TW'(u1), TW'(u0)};
    endtask

    // Reference model: a queue of issued entries, newest first. An entry's
    // remaining latency is its issue latency minus the cycles spent since.
    typedef struct { bit we; int dst; int tnew; } ent_t;
    ent_t q[$];

    task automatic model_clear();
        ent_t b;
        b = '{0, 0, 0};
        q.delete();
        for (int k = 0; k < ST; k++) q.push_back(b);
    endtask

    task automatic model_edge(input bit rst, input bit we, input bit nop, input int dst,
                              input int tnew, input bit st, input bit fl);
        ent_t e;
        if (rst) begin
            model_clear();
        end else begin
            if (st || fl) e = '{0, 0, 0};
            else          e = '{we && !nop && dst != 0, dst, tnew};
            q.push_front(e);
            void'(q.pop_back());
        end
    endtask

    task automatic model_op(input int src, input int tuse, output bit stl, output int sel);
        int rem;
        stl = 0; sel = 0;
        for (int k = 0; k < ST; k++) begin
            if (q[k].we && q[k].dst == src && src != 0) begin
                rem = q[k].tnew - k;
                if (rem < 0) rem = 0;
                stl = rem > tuse;
                sel = (rem == 0) ? k + 1 : 0;
                break;
            end
        end
    endtask

    typedef struct {
        logic we, nop; int dst, tnew; logic st, fl;
        int s0, s1, u0, u1;
        int e_we, e_dst1, e_hz, e_f0, e_f1;
    } vec_t;
    vec_t vecs[18];

    int lb_bubbles;

    initial begin
        //            we nop dst tn st fl  s0 s1 u0 u1 | we     dst1 hz f0 f1
        vecs[0]  = '{1, 1, 9, 0, 0, 0,  0, 0, 0, 0,  'b000, 9, 0, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  'b000, 0, 0, 0, 0};
        vecs[2]  = '{1, 0, 9, 0, 0, 0,  9, 0, 0, 0,  'b001, 9, 0, 1, 0};
        vecs[3]  = '{1, 0, 5, 0, 0, 0,  9, 5, 0, 1,  'b011, 5, 0, 2, 1};
        vecs[4]  = '{1, 0, 5, 1, 0, 0,  9, 5, 0, 1,  'b111, 5, 0, 3, 0};
        vecs[5]  = '{0, 0, 0, 0, 0, 0,  9, 5, 0, 1,  'b110, 0, 0, 0, 2};
        vecs[6]  = '{1, 0, 7, 3, 0, 0,  7, 5, 0, 1,  'b101, 7, 1, 0, 3};
        vecs[7]  = '{0, 0, 0, 0, 0, 0,  7, 5, 0, 1,  'b010, 0, 1, 0, 0};
        vecs[8]  = '{0, 0, 0, 0, 0, 0,  7, 5, 0, 1,  'b100, 0, 1, 0, 0};
        vecs[9]  = '{0, 0, 0, 0, 0, 0,  7, 5, 0, 1,  'b000, 0, 0, 0, 0};
        vecs[10] = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  'b000, 0, 0, 0, 0};
        vecs[11] = '{1, 0, 3, 0, 1, 0,  3, 0, 0, 0,  'b000, 0, 0, 0, 0};
        vecs[12] = '{1, 0, 3, 0, 0, 1,  3, 0, 0, 0,  'b000, 0, 0, 0, 0};
        vecs[13] = '{1, 0, 3, 0, 1, 1,  3, 0, 0, 0,  'b000, 0, 0, 0, 0};
        vecs[14] = '{1, 0, 3, 0, 0, 0,  3, 0, 0, 0,  'b001, 3, 0, 1, 0};
        vecs[15] = '{1, 0, 3, 2, 0, 0,  3, 0, 2, 0,  'b011, 3, 0, 0, 0};
        vecs[16] = '{0, 0, 0, 0, 0, 0,  3, 0, 1, 0,  'b110, 0, 0, 0, 0};
        vecs[17] = '{0, 0, 0, 0, 0, 0,  3, 0, 0, 0,  'b100, 0, 0, 3, 0};

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        set_src(0, 0, 0, 0);
        step(); step();
        reset = 1'b0;
        check("reset_we", int'(stg_we), 0);
        check("reset_dst", int'(stg_dst), 0);
        check("reset_hz", int'(hz_stall), 0);
        check("reset_fwd", int'(fwd_sel), 0);

        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].nop, vecs[i].dst, vecs[i].tnew, vecs[i].st, vecs[i].fl);
            set_src(vecs[i].s0, vecs[i].s1, vecs[i].u0, vecs[i].u1);
            step();
            check($sformatf("vec%0d_we", i), int'(stg_we), vecs[i].e_we);
            check($sformatf("vec%0d_dst1", i), int'(stg_dst[0 +: AW]), vecs[i].e_dst1);
            check($sformatf("vec%0d_hz", i), int'(hz_stall), vecs[i].e_hz);
            check($sformatf("vec%0d_fwd0", i), int'(fwd_sel[0 +: SW]), vecs[i].e_f0);
            check($sformatf("vec%0d_fwd1", i), int'(fwd_sel[SW +: SW]), vecs[i].e_f1);
        end

        // Load-use: producer $8 with tnew=2, consumer wants it immediately.
        drive(0, 0, 0, 0, 0, 0); set_src(0, 0, 0, 0);
        step(); step(); step();
        drive(1, 0, 8, 2, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        set_src(8, 0, 0, 0);
        #1;
        lb_bubbles = 0;
        check("lu_c1_hz", int'(hz_stall), 1);
        check("lu_c1_we", int'(stg_we), 'b001);
        stall = hz_stall;
        step();
        if (!stg_we[0]) lb_bubbles++;
        check("lu_c2_hz", int'(hz_stall), 1);
        check("lu_c2_we", int'(stg_we), 'b010);
        stall = hz_stall;
        step();
        if (!stg_we[0]) lb_bubbles++;
        check("lu_c3_hz", int'(hz_stall), 0);
        check("lu_c3_we", int'(stg_we), 'b100);
        check("lu_c3_fwd0", int'(fwd_sel[0 +: SW]), 3);
        check("lu_bubbles", lb_bubbles, 2);
        stall = hz_stall;

        // stall+flush together, then reset with an entry in stage 2.
        drive(1, 0, 4, 0, 0, 0);
        step();
        drive(1, 0, 6, 0, 1, 1);
        set_src(4, 6, 0, 0);
        step();
        check("sf_we", int'(stg_we), 'b010);
        check("sf_dst2", int'(stg_dst[AW +: AW]), 4);
        check("sf_fwd0", int'(fwd_sel[0 +: SW]), 2);
        drive(1, 0, 6, 0, 0, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_we", int'(stg_we), 0);
        check("rst_mid_dst", int'(stg_dst), 0);
        check("rst_mid_fwd", int'(fwd_sel), 0);
        check("rst_mid_hz", int'(hz_stall), 0);

        // Randomized traffic vs model; inputs change mid-cycle, outputs
        // checked before the edge that consumes them.
        model_clear();
        for (int c = 0; c < 600; c++) begin
            bit m_hz, s0b, s1b;
            int f0, f1, s0, s1, u0, u1;
            logic r_rst, r_we, r_nop, r_st, r_fl;
            int r_dst, r_tn;
            r_rst = ($urandom_range(0, 59) == 0);
            r_we  = ($urandom_range(0, 3) != 0);
            r_nop = ($urandom_range(0, 9) == 0);
            r_dst = $urandom_range(0, 7);
            r_tn  = $urandom_range(0, 3);
            r_st  = ($urandom_range(0, 7) == 0);
            r_fl  = ($urandom_range(0, 9) == 0);
            s0 = $urandom_range(0, 7); s1 = $urandom_range(0, 7);
            u0 = $urandom_range(0, 3); u1 = $urandom_range(0, 3);
            reset = r_rst;
            drive(r_we, r_nop, r_dst, r_tn, r_st, r_fl);
            set_src(s0, s1, u0, u1);
            #1;
            model_op(s0, u0, s0b, f0);
            model_op(s1, u1, s1b, f1);
            m_hz = s0b | s1b;
            for (int k = 0; k < ST; k++) begin
                check($sformatf("rnd%0d_we%0d", c, k), int'(stg_we[k]), int'(q[k].we));
                check($sformatf("rnd%0d_dst%0d", c, k), int'(stg_dst[k*AW +: AW]), q[k].dst);
            end
            check($sformatf("rnd%0d_hz", c), int'(hz_stall), int'(m_hz));
            check($sformatf("rnd%0d_fwd0", c), int'(fwd_sel[0 +: SW]), f0);
            check($sformatf("rnd%0d_fwd1", c), int'(fwd_sel[SW +: SW]), f1);
            step();
            model_edge(r_rst, r_we, r_nop, r_dst, r_tn, r_st, r_fl);
        end

        // Reset after random traffic.
        reset = 1'b1;
        drive(1, 0, 5, 0, 0, 0);
        step();
        reset = 1'b0;
        set_src(5, 5, 0, 0);
        #1;
        check("post_rnd_reset_we", int'(stg_we), 0);
        check("post_rnd_reset_hz", int'(hz_stall), 0);
        check("post_rnd_reset_fwd", int'(fwd_sel), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
